// File: rtl/uart_baud_gen_mc.sv
// Multi-channel UART baud generator: per-channel integer + fractional
// divisor, oversample counter and shadowed runtime reconfiguration.
module uart_baud_gen_mc #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 13,
    parameter int FRAC_W         = 3,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_BAUD_VAL = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          enable,
    input  logic [NUM_CH-1:0]          cfg_load,
    input  logic [NUM_CH*CNT_W-1:0]    baud_val,
    input  logic [NUM_CH*FRAC_W-1:0]   baud_frac,
    output logic [NUM_CH-1:0]          baud_tick,
    output logic [NUM_CH-1:0]          xmit_tick
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_BAUD_VAL);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [CNT_W-1:0]  sh_val_q, sh_val_d;
        logic [FRAC_W-1:0] acc_q, acc_d;
        logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
        logic [OS_W-1:0]   os_q, os_d;
        logic              stretch_q, stretch_d;
        logic              bt_q, bt_d;
        logic              xt_q, xt_d;
        logic [FRAC_W:0]   sum;

        always_comb begin
            sum       = {1'b0, acc_q} + {1'b0, sh_frac_q};
            cnt_d     = cnt_q;
            acc_d     = acc_q;
            os_d      = os_q;
            stretch_d = stretch_q;
            bt_d      = 1'b0;
            xt_d      = 1'b0;
            sh_val_d  = sh_val_q;
            sh_frac_d = sh_frac_q;

            // Shadow capture is independent of enable; the count path
            // below only ever reads the old shadow values.
            if (cfg_load[g]) begin
                sh_val_d  = baud_val[g*CNT_W +: CNT_W];
                sh_frac_d = baud_frac[g*FRAC_W +: FRAC_W];
            end

            if (!enable[g]) begin
                cnt_d     = '0;
                acc_d     = '0;
                os_d      = '0;
                stretch_d = 1'b0;
            end else if (cnt_q == '0 && stretch_q) begin
                stretch_d = 1'b0;
            end else if (cnt_q == '0) begin
                bt_d      = 1'b1;
                cnt_d     = sh_val_q;
                acc_d     = sum[FRAC_W-1:0];
                stretch_d = sum[FRAC_W];
                xt_d      = (os_q == OS_LAST);
                os_d      = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q     <= '0;
                acc_q     <= '0;
                os_q      <= '0;
                stretch_q <= 1'b0;
                bt_q      <= 1'b0;
                xt_q      <= 1'b0;
                sh_val_q  <= RST_VAL;
                sh_frac_q <= '0;
            end else begin
                cnt_q     <= cnt_d;
                acc_q     <= acc_d;
                os_q      <= os_d;
                stretch_q <= stretch_d;
                bt_q      <= bt_d;
                xt_q      <= xt_d;
                sh_val_q  <= sh_val_d;
                sh_frac_q <= sh_frac_d;
            end
        end

        assign baud_tick[g] = bt_q;
        assign xmit_tick[g] = xt_q;
    end

endmodule

// File: tb/tb_uart_baud_gen_mc.sv
// Bench for uart_baud_gen_mc: directed cases plus randomized traffic
// checked cycle by cycle against a tick-schedule reference model.
module tb_uart_baud_gen_mc;

    localparam int NCH = 2;
    localparam int CW  = 13;
    localparam int FW  = 3;
    localparam int OS  = 16;
    localparam int RBV = 2;
    localparam int M   = 1 << FW;

    logic               clk;
    logic               reset;
    logic [NCH-1:0]     enable;
    logic [NCH-1:0]     cfg_load;
    logic [NCH*CW-1:0]  baud_val;
    logic [NCH*FW-1:0]  baud_frac;
    logic [NCH-1:0]     baud_tick;
    logic [NCH-1:0]     xmit_tick;

    uart_baud_gen_mc #(
        .NUM_CH(NCH), .CNT_W(CW), .FRAC_W(FW),
        .OVERSAMPLE(OS), .RESET_BAUD_VAL(RBV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_load(cfg_load), .baud_val(baud_val),
        .baud_frac(baud_frac), .baud_tick(baud_tick),
        .xmit_tick(xmit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: absolute cycle of the next tick per channel,
    // with the fraction handled as a running sum modulo 2^FW.
    longint cyc;
    bit     m_run[NCH];
    longint m_next[NCH];
    int     m_ticks[NCH];
    int     m_fsum[NCH];
    int     m_shv[NCH];
    int     m_shf[NCH];
    bit     m_bt[NCH];
    bit     m_xt[NCH];

    task automatic model_rst();
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_next[c] = 0; m_ticks[c] = 0;
            m_fsum[c] = 0; m_shv[c] = RBV; m_shf[c] = 0;
            m_bt[c] = 0; m_xt[c] = 0;
        end
    endtask

    task automatic model_edge();
        int carry;
        cyc++;
        if (reset) begin
            model_rst();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            m_bt[c] = 0;
            m_xt[c] = 0;
            if (!enable[c]) begin
                m_run[c] = 0; m_ticks[c] = 0; m_fsum[c] = 0;
            end else if (!m_run[c] || cyc == m_next[c]) begin
                m_run[c] = 1;
                carry = (m_fsum[c] + m_shf[c]) >= M ? 1 : 0;
                m_fsum[c] = (m_fsum[c] + m_shf[c]) % M;
                m_next[c] = cyc + m_shv[c] + 1 + carry;
                m_ticks[c]++;
                m_bt[c] = 1;
                m_xt[c] = (m_ticks[c] % OS) == 0;
            end
            if (cfg_load[c]) begin
                m_shv[c] = int'(baud_val[c*CW +: CW]);
                m_shf[c] = int'(baud_frac[c*FW +: FW]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("baud_tick%0d", c), int'(baud_tick[c]), int'(m_bt[c]));
            chk($sformatf("xmit_tick%0d", c), int'(xmit_tick[c]), int'(m_xt[c]));
        end
    endtask

    task automatic load(input int c, input int v, input int f);
        baud_val[c*CW +: CW]  = CW'(v);
        baud_frac[c*FW +: FW] = FW'(f);
        cfg_load[c] = 1'b1;
        cycle();
        cfg_load[c] = 1'b0;
    endtask

    task automatic span(input int c, input int n, output int res);
        int seen = 0;
        int t0 = 0;
        res = -1;
        for (int t = 1; t < 4000 && seen <= n; t++) begin
            cycle();
            if (baud_tick[c]) begin
                if (seen == 0) t0 = t;
                seen++;
                if (seen == n + 1) res = t - t0;
            end
        end
    endtask

    task automatic async_reset(input int hold);
        #2;
        reset = 1'b1;
        model_rst();
        #1;
        chk("rst_baud_tick", int'(baud_tick), 0);
        chk("rst_xmit_tick", int'(xmit_tick), 0);
        repeat (hold) cycle();
        reset = 1'b0;
    endtask

    int nt;
    int res;
    bit seen_x;

    initial begin
        cyc = 0;
        model_rst();
        reset = 1'b1;
        enable = '0;
        cfg_load = '0;
        baud_val = '0;
        baud_frac = '0;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Divisor 3, no fraction: first tick next edge, xmit on 16th tick.
        load(0, 3, 0);
        enable[0] = 1'b1;
        cycle();
        chk("enable_latency", int'(baud_tick[0]), 1);
        nt = 1;
        seen_x = 0;
        for (int k = 0; k < 200 && !seen_x; k++) begin
            cycle();
            if (baud_tick[0]) nt++;
            if (xmit_tick[0]) seen_x = 1;
        end
        chk("first_xmit_tick_index", nt, 16);

        // 3 + 4/8: intervals alternate 4,5; 16 ticks span 72 cycles.
        enable[0] = 1'b0;
        cycle();
        load(0, 3, 4);
        enable[0] = 1'b1;
        span(0, 16, res);
        chk("span_3_4", res, 72);

        // Reconfigure 7 -> 2 mid-count, then a load on a reload edge.
        enable[0] = 1'b0;
        cycle();
        load(0, 7, 0);
        enable[0] = 1'b1;
        repeat (3) cycle();
        load(0, 2, 0);
        repeat (30) cycle();
        for (int k = 0; k < 20 && !baud_tick[0]; k++) cycle();
        repeat (2) cycle();
        load(0, 5, 0);
        repeat (30) cycle();

        // 0 + 7/8: 64 ticks span 120 cycles.
        enable[0] = 1'b0;
        cycle();
        load(0, 0, 7);
        enable[0] = 1'b1;
        span(0, 64, res);
        chk("span_0_7", res, 120);

        // Reset mid-stretch, then sh_val must be back to its reset value.
        enable[0] = 1'b0;
        cycle();
        load(0, 3, 7);
        enable[0] = 1'b1;
        repeat (10) cycle();
        async_reset(2);
        cycle();
        chk("post_reset_first_tick", int'(baud_tick[0]), 1);
        span(0, 4, res);
        chk("post_reset_period", res, 4 * (RBV + 1));

        // Two channels running together, random reconfig and enable[1] toggles.
        load(0, 0, 3);
        load(1, 5, 5);
        enable = 2'b11;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 49) == 0) enable[1] = ~enable[1];
            for (int c = 0; c < NCH; c++) begin
                cfg_load[c] = ($urandom_range(0, 63) == 0);
                baud_val[c*CW +: CW]  = CW'($urandom_range(0, 9));
                baud_frac[c*FW +: FW] = FW'($urandom_range(0, M - 1));
            end
            if (k > 8000 && $urandom_range(0, 499) == 0) begin
                cfg_load = '0;
                async_reset($urandom_range(1, 3));
            end else begin
                cycle();
            end
        end
        cfg_load = '0;
        enable = '0;
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
